// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate truth-table sweeper.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned NUM_VEC(input int unsigned n);
    return 32'd1 << n;
  endfunction

  localparam logic [3:0] TRUTH_AND2 = 4'b1000;
  localparam logic [3:0] TRUTH_OR2  = 4'b1110;
  localparam logic [3:0] TRUTH_XOR2 = 4'b0110;

endpackage

// File: rtl/sweep_settle_timer.sv
// Down-counter that paces how long each input vector is held before sampling.
module sweep_settle_timer #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int unsigned W = $clog2(SETTLE_CYC + 1);
  localparam logic [W-1:0] RELOAD = W'(SETTLE_CYC - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (tick && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gate_truth_sweeper.sv
// Walks a combinational gate through all input vectors and checks each result
// against an expected truth table, reporting error count and first failure.
module gate_truth_sweeper
  import gate_sweep_pkg::*;
#(
  parameter int unsigned                N_IN       = 2,
  parameter logic [NUM_VEC(N_IN)-1:0]   TRUTH      = TRUTH_AND2,
  parameter int unsigned                SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int unsigned VW = N_IN + 1;
  localparam logic [VW-1:0] LAST_VEC = VW'(NUM_VEC(N_IN) - 1);

  state_t        state;
  logic [VW-1:0] vec;
  logic          expired;
  logic          sample;
  logic          mismatch;
  logic          accept;
  logic          load;
  logic          tick;
  logic [N_IN:0] err_next;

  always_comb begin
    accept   = start && (state != HOLD);
    sample   = (state == HOLD) && expired;
    mismatch = (dut_out != TRUTH[vec[N_IN-1:0]]);
    err_next = err_count;
    if (mismatch && err_count != '1) begin
      err_next = err_count + 1'b1;
    end
    load = accept || (sample && vec != LAST_VEC);
    tick = (state == HOLD) && !expired;
  end

  sweep_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .tick   (tick),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      vec              <= '0;
      dut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= HOLD;
            vec              <= '0;
            dut_in           <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (expired) begin
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_vec   <= vec[N_IN-1:0];
              first_fail_valid <= 1'b1;
            end
            // pass uses err_next so the last vector's verdict is included
            if (vec == LAST_VEC) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (err_next == '0);
              dut_in <= '0;
            end else begin
              vec    <= vec + 1'b1;
              dut_in <= vec[N_IN-1:0] + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Self-checking bench: table vectors, random gate tables against a truth-table
// model, and hand sequences for restart, re-start-in-DONE and async reset.
module tb_gate_truth_sweeper;
  import gate_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: 2-input, AND truth table, gate behaviour set by gate_a
  logic       start_a = 1'b0;
  logic [3:0] gate_a = TRUTH_AND2;
  logic [1:0] in_a, ff_a;
  logic [2:0] err_a;
  logic       out_a, busy_a, done_a, pass_a, ffv_a;
  assign out_a = gate_a[in_a];

  gate_truth_sweeper #(.N_IN(2), .TRUTH(TRUTH_AND2), .SETTLE_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(out_a), .dut_in(in_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ff_a), .first_fail_valid(ffv_a));

  // Instance B: wrong expectation 4'b1001 against a real AND gate
  logic       start_b = 1'b0;
  logic [1:0] in_b, ff_b;
  logic [2:0] err_b;
  logic       out_b, busy_b, done_b, pass_b, ffv_b;
  assign out_b = &in_b;

  gate_truth_sweeper #(.N_IN(2), .TRUTH(4'b1001), .SETTLE_CYC(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(out_b), .dut_in(in_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ff_b), .first_fail_valid(ffv_b));

  // Instance C: 3-input AND, 3-cycle settle window
  logic       start_c = 1'b0;
  logic [7:0] gate_c = 8'h80;
  logic [2:0] in_c, ff_c;
  logic [3:0] err_c;
  logic       out_c, busy_c, done_c, pass_c, ffv_c;
  assign out_c = gate_c[in_c];

  gate_truth_sweeper #(.N_IN(3), .TRUTH(8'b1000_0000), .SETTLE_CYC(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .dut_out(out_c), .dut_in(in_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_fail_vec(ff_c), .first_fail_valid(ffv_c));

  typedef struct {
    logic [3:0] g;
    int         err;
    int         ff;
    bit         pass;
  } vec_rec_t;

  vec_rec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected results straight from the truth-table definition.
  task automatic model(input logic [7:0] g, input logic [7:0] truth, input int nv,
                       output int err, output int ff);
    err = 0;
    ff  = -1;
    for (int i = 0; i < nv; i++) begin
      if (g[i] != truth[i]) begin
        err++;
        if (ff < 0) ff = i;
      end
    end
  endtask

  task automatic sweep_a(input logic [3:0] g, input int e_err, input int e_ff,
                         input bit e_pass, input string tag);
    gate_a  = g;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk({tag, "_busy"}, 32'(busy_a), 32'd1);
    chk({tag, "_pass_busy"}, 32'(pass_a), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_in"}, 32'(in_a), 32'(k));
      chk({tag, "_done_early"}, 32'(done_a), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, 32'(done_a), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy_a), 32'd0);
    chk({tag, "_in_end"}, 32'(in_a), 32'd0);
    chk({tag, "_err"}, 32'(err_a), 32'(e_err));
    chk({tag, "_pass"}, 32'(pass_a), 32'(e_pass));
    chk({tag, "_ffv"}, 32'(ffv_a), 32'(e_ff >= 0));
    if (e_ff >= 0) chk({tag, "_ff"}, 32'(ff_a), 32'(e_ff));
  endtask

  task automatic sweep_c(input logic [7:0] g, input int e_err, input int e_ff, input string tag);
    gate_c  = g;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    for (int j = 0; j < 24; j++) begin
      chk({tag, "_in"}, 32'(in_c), 32'(j / 3));
      chk({tag, "_done_early"}, 32'(done_c), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, 32'(done_c), 32'd1);
    chk({tag, "_err"}, 32'(err_c), 32'(e_err));
    chk({tag, "_pass"}, 32'(pass_c), 32'(e_err == 0));
    chk({tag, "_ffv"}, 32'(ffv_c), 32'(e_ff >= 0));
    if (e_ff >= 0) chk({tag, "_ff"}, 32'(ff_c), 32'(e_ff));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e_err, e_ff;
    logic [3:0] rg;
    logic [7:0] rg8;

    tbl[0] = '{4'b1000, 0, -1, 1'b1};
    tbl[1] = '{4'b1111, 3,  0, 1'b0};
    tbl[2] = '{4'b0000, 1,  3, 1'b0};
    tbl[3] = '{4'b0111, 4,  0, 1'b0};
    tbl[4] = '{4'b1100, 1,  2, 1'b0};
    tbl[5] = '{4'b1010, 1,  1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_in", 32'(in_a), 32'd0);
    chk("rst_ffv", 32'(ffv_a), 32'd0);
    chk("rst_in_c", 32'(in_c), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      sweep_a(tbl[i].g, tbl[i].err, tbl[i].ff, tbl[i].pass, $sformatf("tbl%0d", i));
    end

    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b_done", 32'(done_b), 32'd1);
    chk("b_err", 32'(err_b), 32'd1);
    chk("b_ff", 32'(ff_b), 32'd0);
    chk("b_ffv", 32'(ffv_b), 32'd1);
    chk("b_pass", 32'(pass_b), 32'd0);

    sweep_c(8'h80, 0, -1, "c_and3");

    for (int i = 0; i < 16; i++) begin
      rg = 4'($urandom);
      model({4'b0, rg}, {4'b0, TRUTH_AND2}, 4, e_err, e_ff);
      sweep_a(rg, e_err, e_ff, e_err == 0, $sformatf("rnd_a%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      rg8 = 8'($urandom);
      model(rg8, 8'h80, 8, e_err, e_ff);
      sweep_c(rg8, e_err, e_ff, $sformatf("rnd_c%0d", i));
    end

    // start re-pulsed at E0+2 is ignored
    gate_a  = TRUTH_AND2;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("restart_in", 32'(in_a), 32'd2);
    chk("restart_busy", 32'(busy_a), 32'd1);
    @(posedge clk); #1;
    chk("restart_in3", 32'(in_a), 32'd3);
    chk("restart_done_early", 32'(done_a), 32'd0);
    @(posedge clk); #1;
    chk("restart_done", 32'(done_a), 32'd1);
    chk("restart_pass", 32'(pass_a), 32'd1);

    // start while DONE clears results and reruns from vector 0
    sweep_a(4'b1111, 3, 0, 1'b0, "pre_clear");
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("clear_err", 32'(err_a), 32'd0);
    chk("clear_done", 32'(done_a), 32'd0);
    chk("clear_pass", 32'(pass_a), 32'd0);
    chk("clear_ffv", 32'(ffv_a), 32'd0);
    chk("clear_in", 32'(in_a), 32'd0);
    chk("clear_busy", 32'(busy_a), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("clear_rerun_done", 32'(done_a), 32'd1);
    chk("clear_rerun_err", 32'(err_a), 32'd3);

    // asynchronous reset mid-sweep
    gate_a  = 4'b1111;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arst_pre_in", 32'(in_a), 32'd2);
    chk("arst_pre_err", 32'(err_a), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_in", 32'(in_a), 32'd0);
    chk("arst_err", 32'(err_a), 32'd0);
    chk("arst_ffv", 32'(ffv_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_idle_done", 32'(done_a), 32'd0);
    chk("arst_idle_busy", 32'(busy_a), 32'd0);
    sweep_a(TRUTH_AND2, 0, -1, 1'b1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
